// File: rtl/regwb_pkg.sv
// rtl/regwb_pkg.sv - shared register-file writeback constants
package regwb_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  localparam int WB_ALU  = 0;
  localparam int WB_LOAD = 1;
  localparam int WB_MDU  = 2;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, search starts at ptr_i
module rr_arbiter #(
  parameter int N  = 3,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  int j;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!any_o && valid_i[j]) begin
        any_o      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = PW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin sharing of the register-file write port
// Optional read bypass of the in-flight write: REGWB_BYPASS_EN
module regfile_wb_arbiter
  import regwb_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int DW   = RF_DW,
  parameter int AW   = RF_AW
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic               stall,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic               busy,
  input  logic [AW-1:0]      byp_raddr1,
  input  logic [AW-1:0]      byp_raddr2,
  output logic               byp_hit1,
  output logic               byp_hit2,
  output logic [DW-1:0]      byp_data1,
  output logic [DW-1:0]      byp_data2
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic            we_q, we_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic [NREQ-1:0] arb_grant;
  logic [PW-1:0]   arb_idx;
  logic            arb_any;
  logic            grant_en;
  logic [AW-1:0]   g_addr;
  logic [DW-1:0]   g_data;

  rr_arbiter #(.N(NREQ), .PW(PW)) u_arb (
    .valid_i (req_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx),
    .any_o   (arb_any)
  );

  // No grant may be handed out while reset holds the output stage clear.
  assign grant_en  = arb_any & ~stall & resetn;
  assign req_ready = grant_en ? arb_grant : '0;
  assign busy      = |(req_valid & ~req_ready);

  assign g_addr = req_addr[int'(arb_idx)*AW +: AW];
  assign g_data = req_data[int'(arb_idx)*DW +: DW];

  always_comb begin
    ptr_d   = ptr_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (grant_en) begin
      waddr_d = g_addr;
      wdata_d = g_data;
      // x0 writes are consumed but never reach the register file
      we_d    = (g_addr != '0);
      ptr_d   = (arb_idx == PW'(NREQ - 1)) ? '0 : arb_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr_q   <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;

`ifdef REGWB_BYPASS_EN
  assign byp_hit1  = we_q && (waddr_q == byp_raddr1);
  assign byp_hit2  = we_q && (waddr_q == byp_raddr2);
  assign byp_data1 = wdata_q;
  assign byp_data2 = wdata_q;
`else
  logic unused_byp;
  assign unused_byp = ^{byp_raddr1, byp_raddr2};
  assign byp_hit1   = 1'b0;
  assign byp_hit2   = 1'b0;
  assign byp_data1  = '0;
  assign byp_data2  = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int DW   = 32;
  localparam int AW   = 5;

  logic               clk = 1'b0;
  logic               resetn;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic               stall;
  logic               rf_we;
  logic [AW-1:0]      rf_waddr;
  logic [DW-1:0]      rf_wdata;
  logic               busy;
  logic [AW-1:0]      byp_raddr1, byp_raddr2;
  logic               byp_hit1, byp_hit2;
  logic [DW-1:0]      byp_data1, byp_data2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .stall      (stall),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy),
    .byp_raddr1 (byp_raddr1),
    .byp_raddr2 (byp_raddr2),
    .byp_hit1   (byp_hit1),
    .byp_hit2   (byp_hit2),
    .byp_data1  (byp_data1),
    .byp_data2  (byp_data2)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = v;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  initial begin
    resetn     = 1'b0;
    req_valid  = '0;
    req_addr   = '0;
    req_data   = '0;
    stall      = 1'b0;
    byp_raddr1 = '0;
    byp_raddr2 = '0;

    // reset with requests pending: nothing granted, outputs cleared
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 3), 32'hA000_0000 + DW'(i));
    tick();
    check_eq("rst_ready", 64'(req_ready), 64'h0);
    check_eq("rst_we", 64'(rf_we), 64'h0);
    check_eq("rst_waddr", 64'(rf_waddr), 64'h0);
    check_eq("rst_wdata", 64'(rf_wdata), 64'h0);
    req_valid = '0;
    tick();
    resetn = 1'b1;
    tick();
    tick();
    check_eq("idle_we", 64'(rf_we), 64'h0);

    // all three valid: grants rotate 0,1,2,0,1,2
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i + 1), 32'h0000_0100 + DW'(i));
    for (int c = 0; c < 6; c++) begin
      #1;
      check_eq($sformatf("rr_ready%0d", c), 64'(req_ready), 64'(3'b001 << (c % 3)));
      check_eq($sformatf("rr_busy%0d", c), 64'(busy), 64'h1);
      tick();
      check_eq($sformatf("rr_we%0d", c), 64'(rf_we), 64'h1);
      check_eq($sformatf("rr_waddr%0d", c), 64'(rf_waddr), 64'((c % 3) + 1));
      check_eq($sformatf("rr_wdata%0d", c), 64'(rf_wdata), 64'(32'h100 + (c % 3)));
    end

    // asynchronous reset mid-burst clears the output stage at once
    #1;
    resetn = 1'b0;
    #1;
    check_eq("arst_we", 64'(rf_we), 64'h0);
    check_eq("arst_waddr", 64'(rf_waddr), 64'h0);
    check_eq("arst_ready", 64'(req_ready), 64'h0);
    req_valid = '0;
    tick();
    resetn = 1'b1;
    tick();

    // x0 write from requester 0: accepted, no write, ptr -> 1
    set_req(0, 1'b1, 5'd0, 32'h1234_5678);
    #1;
    check_eq("x0_ready", 64'(req_ready), 64'b001);
    tick();
    req_valid = '0;
    check_eq("x0_we", 64'(rf_we), 64'h0);
    check_eq("x0_wdata", 64'(rf_wdata), 64'h1234_5678);
    set_req(0, 1'b1, 5'd9, 32'h0000_0009);
    set_req(1, 1'b1, 5'd10, 32'h0000_000A);
    #1;
    check_eq("x0_ptr_adv", 64'(req_ready), 64'b010);
    tick();
    req_valid = '0;
    check_eq("x0_next_waddr", 64'(rf_waddr), 64'd10);
    tick();

    // single requester 1 (ptr now 2, search 2,0,1)
    set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
    #1;
    check_eq("single_ready", 64'(req_ready), 64'b010);
    check_eq("single_busy", 64'(busy), 64'h0);
    tick();
    req_valid = '0;
    check_eq("single_we", 64'(rf_we), 64'h1);
    check_eq("single_waddr", 64'(rf_waddr), 64'd5);
    check_eq("single_wdata", 64'(rf_wdata), 64'hDEAD_BEEF);
    tick();
    check_eq("single_we_off", 64'(rf_we), 64'h0);
    check_eq("single_waddr_hold", 64'(rf_waddr), 64'd5);

    // stall holds off requester 2 for three cycles
    stall = 1'b1;
    set_req(2, 1'b1, 5'd7, 32'hCAFE_F00D);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_eq($sformatf("stall_ready%0d", c), 64'(req_ready), 64'h0);
      check_eq($sformatf("stall_busy%0d", c), 64'(busy), 64'h1);
      tick();
      check_eq($sformatf("stall_we%0d", c), 64'(rf_we), 64'h0);
    end
    stall = 1'b0;
    #1;
    check_eq("unstall_ready", 64'(req_ready), 64'b100);
    tick();
    req_valid  = '0;
    byp_raddr1 = 5'd7;
    byp_raddr2 = 5'd8;
    #1;
    check_eq("unstall_we", 64'(rf_we), 64'h1);
    check_eq("unstall_waddr", 64'(rf_waddr), 64'd7);
`ifdef REGWB_BYPASS_EN
    check_eq("byp_hit1", 64'(byp_hit1), 64'h1);
    check_eq("byp_data1", 64'(byp_data1), 64'hCAFE_F00D);
`else
    check_eq("byp_hit1", 64'(byp_hit1), 64'h0);
    check_eq("byp_data1", 64'(byp_data1), 64'h0);
`endif
    check_eq("byp_hit2", 64'(byp_hit2), 64'h0);
    tick();
    check_eq("byp_hit1_idle", 64'(byp_hit1), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port arbiter and sequencer for the 32×32 register file. It shares the single register-file write port (we/waddr/wdata) between NREQ writeback requesters: ALU, load unit and mult/div. A round-robin grant and a one-stage registered output provide the sharing. It sits between the execute/memory writeback sources and the register file in the decode stage. Writes to register 0 are dropped, and an optional bypass tap exposes the in-flight write to the read ports.

## Interface
Parameters:
- NREQ, 3, number of writeback requesters (2..8)
- DW, 32, data width
- AW, 5, register address width

Ports:
- clk  in  1  system clock; all state updates on posedge
- resetn  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  requester i has a write pending
- req_ready  out  NREQ  one-hot grant; write i accepted this cycle
- req_addr  in  NREQ*AW  destination register, requester i at bits [i*AW +: AW]
- req_data  in  NREQ*DW  write data, requester i at bits [i*DW +: DW]
- stall  in  1  freeze arbitration; no grants while high
- rf_we  out  1  register-file write enable (registered)
- rf_waddr  out  AW  register-file write address (registered)
- rf_wdata  out  DW  register-file write data (registered)
- busy  out  1  any req_valid high and not granted this cycle
- byp_raddr1, byp_raddr2  in  AW each  read addresses from decode
- byp_hit1, byp_hit2  out  1 each  in-flight write matches read address
- byp_data1, byp_data2  out  DW each  in-flight write data

## Operation
- Round-robin pointer ptr (clog2(NREQ) bits) marks the highest-priority requester.
  - Search order: ptr, ptr+1, …, wrapping modulo NREQ.
- Grant when stall=0: req_ready[g]=1 for the first valid requester g in search order.
  - Grant is combinational from req_valid and ptr.
  - At most one bit of req_ready is high.
- On a posedge with a grant:
  - Capture rf_waddr←req_addr[g] and rf_wdata←req_data[g].
  - rf_we←1 if req_addr[g]≠0, else 0. An x0 write is accepted and consumed but produces no write.
  - ptr←(g+1) mod NREQ.
- On a posedge with no grant (no valid requester, or stall=1):
  - rf_we←0.
  - rf_waddr and rf_wdata hold their values.
  - ptr holds.
- The register file always accepts, so the output stage drains every cycle and needs no back-pressure. One write retires per cycle at most.
- A requester keeps req_valid, req_addr and req_data stable until it sees req_ready. This is a valid/ready handshake; transfer happens on a cycle where both are high.
- busy = |req_valid & ~req_ready.
- Reset values: rf_we=0, rf_waddr=0, rf_wdata=0, ptr=0, req_ready=0 while resetn=0, byp_hit=0.
- Reset asserted mid-operation clears the output stage immediately; the pending write is lost. Requesters must re-present after reset.

## Timing
- Latency: one cycle from the granted posedge to rf_we on the output.
  - The register file commits on the negedge of that output cycle.
  - A write is readable through the register file from the second half of the cycle after the grant.
- Throughput: 1 write/cycle.
- Fairness: a continuously valid requester is granted within NREQ cycles of stall deassertion.
- stall is sampled combinationally; a stall in cycle n suppresses the grant in cycle n.

## Configuration
- REGWB_BYPASS_EN defined:
  - byp_hitK = rf_we && rf_waddr==byp_raddrK, for K = 1, 2.
  - byp_dataK = rf_wdata.
  - Both are purely combinational off the output registers. Decode muxes them over regfile rdata to see the write during the first half-cycle.
- REGWB_BYPASS_EN undefined:
  - byp_hit1/2 are tied to 0 and byp_data1/2 to 0.
  - byp_raddr inputs are ignored.
  - The port list is unchanged.

## Structure
- Shared package regwb_pkg holds:
  - RF_AW=5 and RF_DW=32 constants.
  - Requester index constants WB_ALU=0, WB_LOAD=1, WB_MDU=2.
- Sub-module rr_arbiter (parameter N):
  - Inputs: valid vector and ptr.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational, reused by other shared resources.
- The top level holds ptr, the output registers and the bypass logic.

## Test plan
- Reset, then idle:
  - During resetn=0: req_ready=0, rf_we=0, rf_waddr=0, rf_wdata=0.
  - After resetn rises, no valid requests: rf_we stays 0.
- Single requester: req 1 valid with addr 5, data 0xDEADBEEF → req_ready=3'b010 that cycle; next cycle rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF; the cycle after, rf_we=0.
- All three valid, held for 6 cycles after reset → grants in order 0,1,2,0,1,2; rf_we high every cycle; busy=1 while losers wait.
- x0 write: req 0 valid with addr 0, data 0x12345678 → req_ready[0]=1, next cycle rf_we=0, ptr advances to 1.
- Stall:
  - stall=1 for 3 cycles with req 2 valid → req_ready=0 and rf_we=0 throughout.
  - After stall falls: grant 2, then rf_we=1 the next cycle.
- Bypass with REGWB_BYPASS_EN:
  - While rf_we=1 and rf_waddr=7: byp_raddr1=7 → byp_hit1=1, byp_data1=rf_wdata; byp_raddr2=8 → byp_hit2=0.
  - Without the macro, both hits are 0.
  - Also assert resetn low mid-burst: rf_we drops asynchronously.
